// File: rtl/mem_if.sv
// Control/address bundle between the CPU datapath and the unified memory.
// The shared data bus stays a plain inout net because both sides drive it.
interface mem_if #(
    parameter int WORD_SIZE = 16
);
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;

    modport master (output readM, writeM, address);
    modport slave  (input  readM, writeM, address);
endinterface

// File: rtl/memory.sv
// Unified word-addressed instruction/data memory on the shared CPU data bus.
// One-cycle read latency; writes take priority over reads; async reset clears contents.
module memory #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_if.slave                 bus,
    inout  wire  [WORD_SIZE-1:0] data
);
    localparam int AW = $clog2(DEPTH);

    logic [WORD_SIZE-1:0] mem_r [DEPTH];
    logic [WORD_SIZE-1:0] rdata_r;
    logic [AW-1:0]        index_s;
    logic                 rd_en_s;
    logic                 drive_s;

    // Upper address bits are dropped so addresses alias modulo DEPTH.
    assign index_s = bus.address[AW-1:0];

    generate
        if (AW < WORD_SIZE) begin : g_alias
            logic addr_unused_s;
            assign addr_unused_s = ^bus.address[WORD_SIZE-1:AW];
        end
    endgenerate

    // Read enable and bus drive qualify; a write always wins over a read.
    always_comb begin
        rd_en_s = 1'b0;
        drive_s = 1'b0;
        if (bus.readM && !bus.writeM) begin
            rd_en_s = 1'b1;
            drive_s = reset_n;
        end else begin
            rd_en_s = 1'b0;
            drive_s = 1'b0;
        end
    end

    // Storage array: cleared on reset, written from the bus on writeM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WORD_SIZE{1'b0}};
            end
        end else if (bus.writeM) begin
            mem_r[index_s] <= data;
        end else begin
            mem_r[index_s] <= mem_r[index_s];
        end
    end

    // Read register reloads every edge while a read is requested, holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= {WORD_SIZE{1'b0}};
        end else if (rd_en_s) begin
            rdata_r <= mem_r[index_s];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign data = drive_s ? rdata_r : {WORD_SIZE{1'bz}};
endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: a reference array feeds a scoreboard queue of
// expected read words. Bus release is probed by driving 0 and requiring 0 back.
module tb_memory;
    localparam int W = 16;
    localparam int D = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic           drv_en;
    logic [W-1:0]   drv_val;
    wire  [W-1:0]   data;

    mem_if #(.WORD_SIZE(W)) bus();

    assign data = drv_en ? drv_val : {W{1'bz}};

    memory #(.WORD_SIZE(W), .DEPTH(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .data    (data)
    );

    logic [W-1:0] model [D];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_v;
    int errors = 0;
    int checks = 0;

    task automatic model_clear();
        for (int i = 0; i < D; i++) model[i] = 16'h0000;
        exp_q.delete();
    endtask

    // Called just after a falling edge; the store happens on the next rising edge.
    task automatic do_write(input logic [15:0] a, input logic [15:0] v);
        bus.readM   = 1'b0;
        bus.writeM  = 1'b1;
        bus.address = a;
        drv_en      = 1'b1;
        drv_val     = v;
        @(negedge clk);
        model[a[7:0]] = v;
        bus.writeM  = 1'b0;
        drv_en      = 1'b0;
    endtask

    task automatic issue_read(input logic [15:0] a);
        bus.readM   = 1'b1;
        bus.writeM  = 1'b0;
        bus.address = a;
        exp_q.push_back(model[a[7:0]]);
    endtask

    task automatic test_reset();
        bus.readM = 1'b1;
        bus.address = 16'h0005;
        repeat (2) @(negedge clk);
        drv_en = 1'b1; drv_val = 16'h0000; #1;
        checks++;
        if (data !== 16'h0000) begin errors++; $display("FAIL reset_z: data=%h expected %h", data, 16'h0000); end
        drv_en = 1'b0;
        // write attempted while reset is held must be dropped
        bus.readM = 1'b0; bus.writeM = 1'b1; bus.address = 16'h0006;
        drv_en = 1'b1; drv_val = 16'h5555;
        @(negedge clk);
        bus.writeM = 1'b0; drv_en = 1'b0;
        #2 reset_n = 1'b1;
        @(negedge clk);
        do_write(16'h0005, 16'h7777);
        issue_read(16'h0005);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL pre_reset_rd: data=%h expected %h", data, exp_v); end
        // reset pulse between edges while the block is driving
        #2 reset_n = 1'b0;
        model_clear();
        #1 drv_en = 1'b1; drv_val = 16'h0000;
        #1 checks++;
        if (data !== 16'h0000) begin errors++; $display("FAIL reset_pulse_z: data=%h expected %h", data, 16'h0000); end
        drv_en = 1'b0; reset_n = 1'b1;
        issue_read(16'h0005);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL reset_clears: data=%h expected %h", data, exp_v); end
        issue_read(16'h0006);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL reset_write_drop: data=%h expected %h", data, exp_v); end
    endtask

    task automatic test_write_read();
        do_write(16'h0010, 16'hBEEF);
        issue_read(16'h0010);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL wr_rd: data=%h expected %h", data, exp_v); end
        bus.readM = 1'b0;
        drv_en = 1'b1; drv_val = 16'h0000; #1;
        checks++;
        if (data !== 16'h0000) begin errors++; $display("FAIL rd_off_z: data=%h expected %h", data, 16'h0000); end
        drv_en = 1'b0;
    endtask

    task automatic test_tracking();
        @(negedge clk);
        do_write(16'h0001, 16'h1111);
        do_write(16'h0002, 16'h2222);
        issue_read(16'h0001);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL track_a1: data=%h expected %h", data, exp_v); end
        issue_read(16'h0002);
        #1 checks++;
        if (data !== 16'h1111) begin errors++; $display("FAIL track_hold: data=%h expected %h", data, 16'h1111); end
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL track_a2: data=%h expected %h", data, exp_v); end
    endtask

    task automatic test_write_priority();
        // rdata holds 0x2222 and readM stays high during the combined request
        bus.writeM = 1'b1; bus.address = 16'h0020;
        drv_en = 1'b1; drv_val = 16'h1234;
        #1 checks++;
        if (data !== 16'h1234) begin errors++; $display("FAIL prio_no_drive: data=%h expected %h", data, 16'h1234); end
        @(negedge clk);
        model[8'h20] = 16'h1234;
        bus.writeM = 1'b0; drv_en = 1'b0;
        #1 checks++;
        if (data !== 16'h2222) begin errors++; $display("FAIL prio_rdata_held: data=%h expected %h", data, 16'h2222); end
        issue_read(16'h0020);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL prio_rd: data=%h expected %h", data, exp_v); end
    endtask

    task automatic test_alias();
        do_write(16'h0103, 16'hA5A5);
        issue_read(16'h0003);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL alias_103: data=%h expected %h", data, exp_v); end
        do_write(16'h0007, 16'h0F0F);
        issue_read(16'hFF07);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL alias_ff07: data=%h expected %h", data, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [8];
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 16'($urandom());
            do_write(addrs[i], 16'($urandom()));
        end
        for (int i = 0; i < 8; i++) begin
            issue_read({8'($urandom()), addrs[7-i][7:0]});
            @(negedge clk);
            exp_v = exp_q.pop_front(); checks++;
            if (data !== exp_v) begin errors++; $display("FAIL b2b_rd%0d: data=%h expected %h", i, data, exp_v); end
        end
    endtask

    task automatic test_async_reset_mid_read();
        do_write(16'h0010, 16'hBEEF);
        issue_read(16'h0010);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL amr_rd: data=%h expected %h", data, exp_v); end
        #2 reset_n = 1'b0;
        model_clear();
        #1 drv_en = 1'b1; drv_val = 16'h0000;
        #1 checks++;
        if (data !== 16'h0000) begin errors++; $display("FAIL amr_z: data=%h expected %h", data, 16'h0000); end
        drv_en = 1'b0; reset_n = 1'b1;
        issue_read(16'h0010);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data !== exp_v) begin errors++; $display("FAIL amr_cleared: data=%h expected %h", data, exp_v); end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: sim time=%0t limit=%0t", $time, 50000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drv_en = 1'b0;
        drv_val = 16'h0000;
        reset_n = 1'b0;
        bus.readM = 1'b0;
        bus.writeM = 1'b0;
        bus.address = 16'h0000;
        model_clear();
        test_reset();
        test_write_read();
        test_tracking();
        test_write_priority();
        test_alias();
        test_back_to_back();
        test_async_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory.md
Name: memory

Overview:
- Unified 16-bit word-addressed instruction/data memory for the multi-cycle CPU datapath.
- Sits on the shared bidirectional `data` bus. The CPU drives the bus for stores; this block drives it for loads and instruction fetches.
- Single-port, synchronous access with one-cycle read latency, and an asynchronous active-low reset that clears contents.

Parameters:
- WORD_SIZE, 16, width of the data word and of the address bus.
- DEPTH, 256, number of words implemented; must be a power of two, at most 2^WORD_SIZE.

Ports:
- clk  input  1  system clock; all accesses sample on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- readM  input  1  read request; when high (and writeM low) the block fetches and drives the addressed word.
- writeM  input  1  write request; when high the word on `data` is stored at `address`.
- address  input  WORD_SIZE  word address.
- data  inout  WORD_SIZE  shared data bus; driven by this block only during reads, otherwise high-Z.

Behaviour:
- Storage: array of DEPTH words of WORD_SIZE bits.
  - Index = address[log2(DEPTH)-1:0]; upper address bits are ignored, so addresses alias modulo DEPTH.
  - No error is flagged for aliased addresses.
- Internal read register `rdata` (WORD_SIZE bits).
- Reset, asynchronous on falling reset_n and held while low:
  - every array word = 0x0000;
  - rdata = 0x0000;
  - data bus high-Z;
  - readM/writeM are ignored while reset_n = 0.
- Write:
  - At a rising clk edge with reset_n=1 and writeM=1, the word at index becomes the value sampled on `data`.
  - Single-cycle; no acknowledge.
- Read:
  - At a rising clk edge with reset_n=1, readM=1 and writeM=0, rdata <= array[index].
  - Latency is one cycle: the data are valid on the bus after the first rising edge following assertion of readM/address.
  - rdata reloads on every edge while readM stays high, so an address change is reflected one edge later.
  - When readM=0, rdata holds its value.
- Bus drive:
  - data = rdata when readM=1 and writeM=0 and reset_n=1; otherwise high-Z.
  - The block never drives the bus when writeM=1, which avoids contention with the CPU store driver.
- Simultaneous readM=1 and writeM=1:
  - the write is performed;
  - rdata is not updated;
  - the bus stays high-Z (write priority).
- Read-after-write to the same address in consecutive cycles returns the newly written value; there is no stale-data window.
- Write followed by a read of a different aliased address (same index) returns the written value.
- Reset asserted mid-operation:
  - takes effect immediately, regardless of clk;
  - an in-progress read loses its data (bus goes high-Z);
  - a write on a rising edge coincident with reset_n low is discarded.
- No other state; no internal FSM beyond the rdata register.

Test Plan:
- Reset: pulse reset_n low between clock edges, then readM=1 at address 0x0005 → data = 0x0000 after one rising edge; data is Z while reset_n=0.
- Write/read: writeM=1, address 0x0010, data=0xBEEF for one edge; then readM=1, address 0x0010 → after one edge data = 0xBEEF; with readM=0 data = Z.
- Latency and tracking:
  - preload 0x0001=0x1111 and 0x0002=0x2222;
  - hold readM=1, address 0x0001 → 0x1111 after edge 1;
  - change address to 0x0002 → bus shows 0x1111 until the next edge, then 0x2222.
- Write priority: readM=1 and writeM=1, address 0x0020, data=0x1234 → bus not driven by the block; a subsequent read of 0x0020 returns 0x1234.
- Aliasing: write 0xA5A5 to address 0x0103 (DEPTH=256) → reading 0x0003 returns 0xA5A5.
- Async reset mid-read: while data shows 0xBEEF, drive reset_n low between edges → bus Z immediately; after release, reading 0x0010 returns 0x0000.
